// File: rtl/rca_m_adder.sv
// Registered M-bit ripple-carry adder: explicit full-adder chain, one-cycle
// latency, sum plus unsigned carry-out and two's-complement overflow flags.
module rca_m_adder #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  c_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    output logic [WORD_WIDTH-1:0] r_o,
    output logic                  c_o,
    output logic                  v_o,
    output logic                  valid_o
);

    // Signed overflow: the MSB's carry-in and carry-out disagree.
    function automatic logic signed_ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

    logic [WORD_WIDTH:0]   carry;
    logic [WORD_WIDTH-1:0] sum;
    logic                  ovf;

    assign carry[0] = c_i;

    for (genvar k = 0; k < WORD_WIDTH; k++) begin : g_fa
        assign sum[k]       = a_i[k] ^ b_i[k] ^ carry[k];
        assign carry[k+1]   = (a_i[k] & b_i[k]) | (carry[k] & (a_i[k] ^ b_i[k]));
    end

    // For WORD_WIDTH = 1 carry[0] is c_i, so this reduces to c_o ^ c_i.
    assign ovf = signed_ovf(carry[WORD_WIDTH-1], carry[WORD_WIDTH]);

    // ---- result register stage ----
    logic [WORD_WIDTH-1:0] r_q, r_d;
    logic                  c_q, c_d;
    logic                  v_q, v_d;
    logic                  valid_q, valid_d;

    always_comb begin
        r_d     = r_q;
        c_d     = c_q;
        v_d     = v_q;
        valid_d = 1'b0;
        if (valid_i) begin
            r_d     = sum;
            c_d     = carry[WORD_WIDTH];
            v_d     = ovf;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            c_q     <= c_d;
            v_q     <= v_d;
            valid_q <= valid_d;
        end
    end

    assign r_o     = r_q;
    assign c_o     = c_q;
    assign v_o     = v_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_rca_m_adder.sv
// Bench for rca_m_adder: scoreboard-checked 8-bit instance plus 1- and 32-bit corners.
module tb_rca_m_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, cin;
    logic [7:0] a, b, r;
    logic       co, vo, valo;

    logic       val1, cin1, co1, vo1, valo1;
    logic [0:0] a1, b1, r1;

    logic        val32, cin32, co32, vo32, valo32;
    logic [31:0] a32, b32, r32;

    int n_cmp = 0;
    int n_err = 0;

    rca_m_adder #(.WORD_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .c_i(cin),
        .a_i(a), .b_i(b), .r_o(r), .c_o(co), .v_o(vo), .valid_o(valo)
    );

    rca_m_adder #(.WORD_WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(val1), .c_i(cin1),
        .a_i(a1), .b_i(b1), .r_o(r1), .c_o(co1), .v_o(vo1), .valid_o(valo1)
    );

    rca_m_adder #(.WORD_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(val32), .c_i(cin32),
        .a_i(a32), .b_i(b32), .r_o(r32), .c_o(co32), .v_o(vo32), .valid_o(valo32)
    );

    typedef struct packed {
        logic       c;
        logic       v;
        logic [7:0] r;
    } res_t;

    res_t sbq[$];

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] s;
        res_t e;
        s   = {1'b0, x} + {1'b0, y} + {8'b0, ci};
        e.r = s[7:0];
        e.c = s[8];
        e.v = (x[7] == y[7]) && (s[7] != x[7]);
        return e;
    endfunction

    task automatic apply(input logic vl, input logic rs, input logic [7:0] x,
                         input logic [7:0] y, input logic ci);
        rst   = rs;
        valid = vl;
        a     = x;
        b     = y;
        cin   = ci;
        if (vl && !rs) sbq.push_back(model(x, y, ci));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1);
            n_cmp++;
            if ({valo, co, vo, r} !== 11'h000) begin
                n_err++;
                $display("FAIL reset_hold%0d: got {valid,c,v,r}=%h want 000", i, {valo, co, vo, r});
            end
        end
        n_cmp++;
        if ({valo1, co1, vo1, r1, valo32, co32, vo32, r32} !== 39'h0) begin
            n_err++;
            $display("FAIL reset_corners: got w1=%b%b%b%b w32=%b%b%b%h want zeros",
                     valo1, co1, vo1, r1, valo32, co32, vo32, r32);
        end
        apply(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
        n_cmp++;
        if ({valo, co, vo, r} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_release: got {valid,c,v,r}=%h want 000", {valo, co, vo, r});
        end
    endtask

    task automatic test_basic();
        res_t e;
        apply(1'b1, 1'b0, 8'd23, 8'd42, 1'b0);
        e = sbq.pop_front();
        n_cmp++;
        if ({valo, co, vo, r} !== {1'b1, e.c, e.v, e.r} || r !== 8'd65) begin
            n_err++;
            $display("FAIL basic_add: got {valid,c,v,r}=%b%b%b %0d want 1%b%b 65", valo, co, vo, r, e.c, e.v);
        end
        apply(1'b0, 1'b0, 8'hxx, 8'hxx, 1'bx);
        n_cmp++;
        if ({valo, co, vo, r} !== {1'b0, 1'b0, 1'b0, 8'd65}) begin
            n_err++;
            $display("FAIL basic_hold: got {valid,c,v,r}=%b%b%b %0d want 000 65", valo, co, vo, r);
        end
    endtask

    task automatic test_carry();
        res_t e;
        apply(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);
        e = sbq.pop_front();
        n_cmp++;
        if ({valo, co, vo, r} !== {1'b1, e.c, e.v, e.r} || {co, vo, r} !== 10'h200) begin
            n_err++;
            $display("FAIL carry_ff_01: got {valid,c,v,r}=%b%b%b %h want 110 00", valo, co, vo, r);
        end
        apply(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
        e = sbq.pop_front();
        n_cmp++;
        if ({valo, co, vo, r} !== {1'b1, e.c, e.v, e.r} || {co, vo, r} !== 10'h200) begin
            n_err++;
            $display("FAIL carry_ff_cin: got {valid,c,v,r}=%b%b%b %h want 110 00", valo, co, vo, r);
        end
    endtask

    task automatic test_overflow();
        res_t e;
        apply(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
        e = sbq.pop_front();
        n_cmp++;
        if ({valo, co, vo, r} !== {1'b1, e.c, e.v, e.r} || {co, vo, r} !== 10'h180) begin
            n_err++;
            $display("FAIL ovf_7f_01: got {valid,c,v,r}=%b%b%b %h want 101 80", valo, co, vo, r);
        end
        apply(1'b1, 1'b0, 8'h80, 8'h80, 1'b0);
        e = sbq.pop_front();
        n_cmp++;
        if ({valo, co, vo, r} !== {1'b1, e.c, e.v, e.r} || {co, vo, r} !== 10'h300) begin
            n_err++;
            $display("FAIL ovf_80_80: got {valid,c,v,r}=%b%b%b %h want 111 00", valo, co, vo, r);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        logic rs;
        int   errs_here;
        errs_here = 0;
        for (int i = 0; i < 1000; i++) begin
            rs = (i == 500);
            apply(1'b1, rs, 8'($urandom), 8'($urandom), 1'($urandom));
            n_cmp++;
            if (rs) begin
                if ({valo, co, vo, r} !== 11'h000 || sbq.size() != 0) begin
                    n_err++;
                    $display("FAIL b2b_reset: got {valid,c,v,r}=%h queued=%0d want 000 0", {valo, co, vo, r}, sbq.size());
                end
            end else if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL b2b_queue_empty at %0d: got empty want one entry", i);
            end else begin
                e = sbq.pop_front();
                if ({valo, co, vo, r} !== {1'b1, e.c, e.v, e.r}) begin
                    n_err++;
                    errs_here++;
                    if (errs_here < 10)
                        $display("FAIL b2b_cycle%0d: got {valid,c,v,r}=%b%b%b %h want 1%b%b %h",
                                 i, valo, co, vo, r, e.c, e.v, e.r);
                end
            end
        end
        valid = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_widths();
        valid = 1'b0;
        val1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        val32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h1; cin32 = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({valo1, co1, vo1, r1} !== 4'b1101) begin
            n_err++;
            $display("FAIL w1_1p1p1: got {valid,c,v,r}=%b%b%b%b want 1101", valo1, co1, vo1, r1);
        end
        n_cmp++;
        if ({valo32, co32, vo32, r32} !== {3'b110, 32'h0}) begin
            n_err++;
            $display("FAIL w32_wrap: got {valid,c,v}=%b%b%b r=%h want 110 00000000", valo32, co32, vo32, r32);
        end
        cin1 = 1'b0;
        a32 = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({valo1, co1, vo1, r1} !== 4'b1110) begin
            n_err++;
            $display("FAIL w1_1p1: got {valid,c,v,r}=%b%b%b%b want 1110", valo1, co1, vo1, r1);
        end
        n_cmp++;
        if ({valo32, co32, vo32, r32} !== {3'b101, 32'h8000_0000}) begin
            n_err++;
            $display("FAIL w32_ovf: got {valid,c,v}=%b%b%b r=%h want 101 80000000", valo32, co32, vo32, r32);
        end
        val1 = 1'b0; val32 = 1'b0; a32 = 'x; b32 = 'x; a1 = 'x;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({valo32, co32, vo32, r32} !== {3'b001, 32'h8000_0000} || {valo1, co1, vo1, r1} !== 4'b0110) begin
            n_err++;
            $display("FAIL widths_hold: got w32=%b%b%b %h w1=%b%b%b%b want 001 80000000 0110",
                     valo32, co32, vo32, r32, valo1, co1, vo1, r1);
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; cin = 1'b0; a = '0; b = '0;
        val1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        val32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_widths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
